strobe_array: RTL and testbench
===============================

# strobe_array

Parametrised array of NCH strobe channels. Each channel is numbered at elaboration time from ID_BASE and ID_STRIDE, counts rising edges on its own strobe bit and raises a pending event. A round-robin arbiter drains pending events onto one valid/ready record stream carrying {id, count}. It replaces single-width, display-only per-instance targets and sits between a strobe/clock-vector source and a logging or trace consumer.

## Interface
- NCH, 5: number of channels, ≥1.
- ID_W, 8: width of the channel id field.
- ID_BASE, 0: id of channel 0.
- ID_STRIDE, 1: id increment per channel; id(i) = (ID_BASE + i*ID_STRIDE) mod 2^ID_W.
- CNT_W, 8: per-channel edge counter width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- strobe  in  NCH  per-channel level inputs, synchronous to clk.
- enable  in  1  1 = edges counted; 0 = edges ignored.
- clear  in  1  synchronous clear of counts, pending, overflow; pointer kept.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_id  out  ID_W  id of reported channel.
- out_count  out  CNT_W  channel count at grant.
- overflow  out  NCH  sticky per-channel lost-event flags.
- busy  out  1  any pending bit set, or out_valid is high.

## Operation
- Reset (async): strobe history s_q=0, cnt=0, pending=0, overflow=0, rr pointer=0, out_valid=0, out_id=0, out_count=0.
- Edge detect: rise[i] = strobe[i] & ~s_q[i]. s_q is updated every cycle regardless of enable.
- On rise[i] & enable:
  - cnt[i] <= cnt[i]+1; wraps mod 2^CNT_W.
  - pending[i] <= 1.
  - If pending[i] was already 1 and is not granted this cycle, overflow[i] <= 1 (events coalesce; count stays exact).
- Output register load condition: load = ~out_valid | out_ready.
- Arbiter: when load, it searches pending from pointer p upward, wrapping at NCH-1→0. The first set bit g is the grant:
  - out_valid <= 1, out_id <= id(g), out_count <= cnt[g] (registered value, before any same-cycle increment).
  - pending[g] <= 0; p <= (g+1) mod NCH.
  - If no bit is pending, out_valid <= 0.
- Simultaneous grant and rise on the same channel: the set wins. pending stays 1, cnt increments, no overflow.
- Backpressure: while out_valid & ~out_ready, out_id/out_count are held stable and no grant occurs. Events keep accumulating.
- clear: cnt, pending and overflow go to 0. A record already in the output register completes normally. clear takes priority over a same-cycle rise (that edge is dropped).
- enable=0: no new events. Existing pending records still drain.

## Timing
- A rise sampled at edge k sets pending at k. The record can be valid after edge k+1 (1-cycle latency, output idle).
- Throughput: one record per cycle while out_ready=1.
- Worst-case wait for a pending channel under continuous ready is NCH cycles (round-robin).
- overflow is valid from the edge that detects the lost event. It clears only on clear or rst_n.
- Reset asserted mid-stream: out_valid drops immediately (async) and the record in flight is lost.

## Structure
- Package strobe_pkg: function chan_id(i, ID_BASE, ID_STRIDE, ID_W), and the record typedef {id, count} as a parametrised struct or width constants.
- Sub-module strobe_channel: one instance per channel via generate/instance array. It holds s_q, cnt, pending and overflow; inputs are strobe bit, enable, clear and grant.
- The top level holds the round-robin arbiter and the output register.

## Test plan
- Walking one, NCH=5: strobe=1, shift left every 2 cycles until 0, out_ready=1 → exactly 5 records, ids 0,1,2,3,4 in order, each count=1, overflow=0.
- All 5 strobes rise together, out_ready=1 → records on 5 consecutive cycles, ids 0..4. busy falls the cycle after the last record.
- Backpressure: channel 3 rises, out_ready=0 for 4 cycles → out_valid=1 with id=3 held stable. Release ready → 1 record, then out_valid=0.
- Overflow: out_ready=0, channel 2 rises twice → overflow[2]=1. On release, a single record id=2, count=2. A following clear → overflow=0.
- ID_BASE=10, ID_STRIDE=3, CNT_W=2: 5 edges on channel 1 with ready=1 → ids all 13, counts 1,2,3,0,1.
- Reset mid-operation with 3 channels pending → out_valid=0 and busy=0 immediately. No records after rst_n release until new edges arrive.

Source files
------------

// File: rtl/strobe_pkg.sv
// Shared widths and channel-id helper for the strobe array.
package strobe_pkg;

   localparam int unsigned ID_W_DEF  = 8;
   localparam int unsigned CNT_W_DEF = 8;

   // Record layout at default widths: {id, count}.
   typedef struct packed {
      logic [ID_W_DEF-1:0]  id;
      logic [CNT_W_DEF-1:0] count;
   } rec_t;

   // id(i) = (base + i*stride) mod 2^id_w, evaluated in 64 bits to avoid early wrap.
   function automatic logic [31:0] chan_id(input int unsigned i,
                                           input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned id_w);
      logic [63:0] sum;
      logic [63:0] mask;
      sum  = 64'(base) + 64'(i) * 64'(stride);
      mask = (id_w >= 64) ? '1 : ((64'(1) << id_w) - 64'(1));
      return 32'(sum & mask);
   endfunction

endpackage

// File: rtl/strobe_channel.sv
// One strobe channel: rise detect, wrapping edge counter, pending and sticky overflow.
module strobe_channel #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strobe_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             grant_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             pending_o,
   output logic             overflow_o
);

   logic             s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             overflow_q, overflow_d;
   logic             event_c;

   assign event_c = strobe_i & ~s_q & enable_i;

   // A same-cycle set beats the grant's clear; clear beats everything.
   always_comb begin
      s_d        = strobe_i;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      if (clear_i) begin
         cnt_d      = '0;
         pending_d  = 1'b0;
         overflow_d = 1'b0;
      end else begin
         if (grant_i) pending_d = 1'b0;
         if (event_c) begin
            cnt_d     = cnt_q + CNT_W'(1);
            pending_d = 1'b1;
            if (pending_q && !grant_i) overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q        <= 1'b0;
         cnt_q      <= '0;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         s_q        <= s_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign pending_o  = pending_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/strobe_array.sv
// Array of strobe channels drained by a round-robin arbiter onto one {id, count} stream.
module strobe_array
   import strobe_pkg::*;
#(
   parameter int unsigned NCH       = 5,
   parameter int unsigned ID_W      = 8,
   parameter int unsigned ID_BASE   = 0,
   parameter int unsigned ID_STRIDE = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   strobe,
   input  logic             enable,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ID_W-1:0]  out_id,
   output logic [CNT_W-1:0] out_count,
   output logic [NCH-1:0]   overflow,
   output logic             busy
);

   localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [CNT_W-1:0] cnt_w [NCH];
   logic [NCH-1:0]   pending_w;
   logic [NCH-1:0]   overflow_w;
   logic [NCH-1:0]   grant_c;

   logic [PW-1:0]    p_q, p_d;
   logic             out_valid_q, out_valid_d;
   logic [ID_W-1:0]  out_id_q, out_id_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             load_c;
   logic             gnt_vld_c;
   logic [PW-1:0]    gnt_idx_c;
   logic [CNT_W-1:0] sel_cnt_c;
   logic [ID_W-1:0]  sel_id_c;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      strobe_channel #(.CNT_W(CNT_W)) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .strobe_i   (strobe[gi]),
         .enable_i   (enable),
         .clear_i    (clear),
         .grant_i    (grant_c[gi]),
         .cnt_o      (cnt_w[gi]),
         .pending_o  (pending_w[gi]),
         .overflow_o (overflow_w[gi])
      );
   end

   assign load_c = ~out_valid_q | out_ready;

   // Round-robin pick: pending channel with the smallest distance above the pointer.
   always_comb begin
      int unsigned best_d;
      int unsigned d;
      best_d    = NCH;
      d         = 0;
      gnt_idx_c = '0;
      sel_cnt_c = '0;
      sel_id_c  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         d = (i >= 32'(p_q)) ? (i - 32'(p_q)) : (i + NCH - 32'(p_q));
         if (pending_w[i] && (d < best_d)) begin
            best_d    = d;
            gnt_idx_c = PW'(i);
            sel_cnt_c = cnt_w[i];
            sel_id_c  = ID_W'(chan_id(i, ID_BASE, ID_STRIDE, ID_W));
         end
      end
      // Events being cleared this cycle are not reported.
      gnt_vld_c = (best_d < NCH) && !clear;
   end

   always_comb begin
      grant_c = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         grant_c[i] = load_c & gnt_vld_c & (gnt_idx_c == PW'(i));
      end
   end

   always_comb begin
      p_d         = p_q;
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      out_count_d = out_count_q;
      if (load_c) begin
         out_valid_d = gnt_vld_c;
         if (gnt_vld_c) begin
            out_id_d    = sel_id_c;
            out_count_d = sel_cnt_c;
            p_d         = (gnt_idx_c == PW'(NCH - 1)) ? '0 : (gnt_idx_c + PW'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_count_q <= '0;
      end else begin
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_count = out_count_q;
   assign overflow  = overflow_w;
   assign busy      = (|pending_w) | out_valid_q;

endmodule

// File: tb/tb_strobe_array.sv
// Directed self-checking bench for strobe_array (default config plus a wrapped-id/count config).
module tb_strobe_array;

   logic       clk;
   logic       rst_n;

   logic [4:0] strobe;
   logic       enable, clear, out_ready;
   logic       out_valid, busy;
   logic [7:0] out_id, out_count;
   logic [4:0] overflow;

   logic [4:0] strobe2;
   logic       enable2, clear2, out_ready2;
   logic       out_valid2, busy2;
   logic [7:0] out_id2;
   logic [1:0] out_count2;
   logic [4:0] overflow2;

   int n_checks = 0;
   int n_errors = 0;

   int id_q[$];
   int cnt_q[$];
   int id2_q[$];
   int cnt2_q[$];

   strobe_array dut (
      .clk(clk), .rst_n(rst_n), .strobe(strobe), .enable(enable), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_count(out_count), .overflow(overflow), .busy(busy)
   );

   strobe_array #(.NCH(5), .ID_W(8), .ID_BASE(10), .ID_STRIDE(3), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .strobe(strobe2), .enable(enable2), .clear(clear2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_id(out_id2),
      .out_count(out_count2), .overflow(overflow2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake monitor: values sampled mid-cycle are those seen at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         id_q.push_back(int'(out_id));
         cnt_q.push_back(int'(out_count));
      end
      if (rst_n && out_valid2 && out_ready2) begin
         id2_q.push_back(int'(out_id2));
         cnt2_q.push_back(int'(out_count2));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush_queues();
      id_q.delete();
      cnt_q.delete();
      id2_q.delete();
      cnt2_q.delete();
   endtask

   initial begin
      int exp_cnt2 [5];
      exp_cnt2 = '{1, 2, 3, 0, 1};

      rst_n = 1'b0; strobe = '0; enable = 1'b1; clear = 1'b0; out_ready = 1'b1;
      strobe2 = '0; enable2 = 1'b1; clear2 = 1'b0; out_ready2 = 1'b1;
      tick(); tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_id", 32'(out_id), 0);
      check("rst_count", 32'(out_count), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      tick();

      // Walking one
      flush_queues();
      for (int k = 0; k < 6; k++) begin
         strobe = (k < 5) ? 5'(1 << k) : 5'd0;
         tick(); tick();
      end
      tick(); tick();
      check("walk_nrec", 32'(id_q.size()), 5);
      for (int i = 0; i < 5 && i < id_q.size(); i++) begin
         check($sformatf("walk_id%0d", i), 32'(id_q[i]), 32'(i));
         check($sformatf("walk_cnt%0d", i), 32'(cnt_q[i]), 1);
      end
      check("walk_overflow", 32'(overflow), 0);
      check("walk_idle", 32'(busy), 0);

      // All strobes rise together
      flush_queues();
      strobe = 5'h1F;
      tick();
      strobe = '0;
      check("all_busy_set", 32'(busy), 1);
      check("all_valid_lat", 32'(out_valid), 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("all_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("all_id%0d", i), 32'(out_id), 32'(i));
         check($sformatf("all_cnt%0d", i), 32'(out_count), 2);
      end
      check("all_busy_last", 32'(busy), 1);
      tick();
      check("all_valid_end", 32'(out_valid), 0);
      check("all_busy_end", 32'(busy), 0);

      // Backpressure on channel 3
      flush_queues();
      out_ready = 1'b0;
      strobe = 5'b01000;
      tick();
      strobe = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
         check($sformatf("bp_id%0d", i), 32'(out_id), 3);
         check($sformatf("bp_cnt%0d", i), 32'(out_count), 3);
      end
      check("bp_nrec_held", 32'(id_q.size()), 0);
      out_ready = 1'b1;
      tick();
      check("bp_valid_end", 32'(out_valid), 0);
      tick();
      check("bp_nrec", 32'(id_q.size()), 1);
      if (id_q.size() > 0) check("bp_rec_id", 32'(id_q[0]), 3);

      // Overflow on channel 2 while the output register is occupied by channel 0
      clear = 1'b1;
      tick();
      clear = 1'b0;
      flush_queues();
      out_ready = 1'b0;
      strobe = 5'b00001; tick();
      strobe = 5'b00000; tick();
      check("ovf_hold_id", 32'(out_id), 0);
      strobe = 5'b00100; tick();
      check("ovf_none_yet", 32'(overflow), 0);
      strobe = 5'b00000; tick();
      strobe = 5'b00100; tick();
      strobe = 5'b00000;
      check("ovf_set", 32'(overflow), 32'(5'b00100));
      check("ovf_held_cnt", 32'(out_count), 1);
      out_ready = 1'b1;
      tick(); tick(); tick();
      check("ovf_valid_end", 32'(out_valid), 0);
      check("ovf_nrec", 32'(id_q.size()), 2);
      if (id_q.size() > 1) begin
         check("ovf_rec0", 32'({id_q[0][7:0], cnt_q[0][7:0]}), 32'(16'h0001));
         check("ovf_rec1", 32'({id_q[1][7:0], cnt_q[1][7:0]}), 32'(16'h0202));
      end
      check("ovf_sticky", 32'(overflow), 32'(5'b00100));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 0);

      // Edges ignored while disabled; the history still tracks the level
      enable = 1'b0;
      strobe = 5'b00010;
      tick(); tick();
      check("dis_valid", 32'(out_valid), 0);
      check("dis_busy", 32'(busy), 0);
      enable = 1'b1;
      tick(); tick();
      check("dis_no_late_rise", 32'(busy), 0);
      strobe = '0;
      tick();

      // Wrapped ids and narrow counter
      flush_queues();
      for (int k = 0; k < 5; k++) begin
         strobe2 = 5'b00010; tick();
         strobe2 = 5'b00000; tick();
      end
      tick();
      check("cfg2_nrec", 32'(id2_q.size()), 5);
      for (int i = 0; i < 5 && i < id2_q.size(); i++) begin
         check($sformatf("cfg2_id%0d", i), 32'(id2_q[i]), 13);
         check($sformatf("cfg2_cnt%0d", i), 32'(cnt2_q[i]), 32'(exp_cnt2[i]));
      end

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      strobe = 5'b01110; tick();
      strobe = '0; tick();
      check("rstm_valid_pre", 32'(out_valid), 1);
      check("rstm_busy_pre", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstm_valid", 32'(out_valid), 0);
      check("rstm_busy", 32'(busy), 0);
      check("rstm_overflow", 32'(overflow), 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      flush_queues();
      repeat (5) tick();
      check("rstm_no_rec", 32'(id_q.size()), 0);
      check("rstm_idle", 32'(out_valid), 0);
      strobe = 5'b10000; tick();
      strobe = '0; tick();
      check("rstm_new_valid", 32'(out_valid), 1);
      check("rstm_new_id", 32'(out_id), 4);
      check("rstm_new_cnt", 32'(out_count), 1);
      tick(); tick();
      check("rstm_new_nrec", 32'(id_q.size()), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
